// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared types for the execute stage. Holds the ALU opcode
//                and condition-code encodings, the NZCV flag struct, the
//                multi-cycle FSM state type and the ARM condition evaluator.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_ORR = 4'd3,
    OP_EOR = 4'd4,
    OP_LSL = 4'd5,
    OP_LSR = 4'd6,
    OP_MOV = 4'd7,
    OP_MUL = 4'd8
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // NV (15) is deliberately folded into AL: it always passes.
  function automatic logic cond_eval(input cond_t cond, input flags_t f);
    logic r;
    case (cond)
      COND_EQ: r = f.z;
      COND_NE: r = ~f.z;
      COND_CS: r = f.c;
      COND_CC: r = ~f.c;
      COND_MI: r = f.n;
      COND_PL: r = ~f.n;
      COND_VS: r = f.v;
      COND_VC: r = ~f.v;
      COND_HI: r = f.c & ~f.z;
      COND_LS: r = ~f.c | f.z;
      COND_GE: r = (f.n == f.v);
      COND_LT: r = (f.n != f.v);
      COND_GT: r = ~f.z & (f.n == f.v);
      COND_LE: r = f.z | (f.n != f.v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_mc_mul.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter
//  Description : Iterative shift-add multiplier producing the low WIDTH bits
//                of an unsigned product, MUL_BPC multiplier bits per cycle.
//  Ports       : clk, rst (sync, active-low)
//                start  - load a/b and begin; ignored unless idle
//                a, b   - multiplicand / multiplier
//                done   - high during the final step; result is valid from
//                         the following cycle until the next start
//                result - accumulated product (low WIDTH bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int c_steps = WIDTH / MUL_BPC;
  localparam int c_cw    = $clog2(c_steps);
  localparam logic [c_cw-1:0] c_last = c_cw'(c_steps - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [c_cw-1:0]  r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_addend;

  // Partial product for the MUL_BPC low multiplier bits. The multiplicand is
  // pre-shifted each step, so only the low WIDTH bits ever matter.
  always_comb begin
    w_addend = '0;
    for (int i = 0; i < MUL_BPC; i++) begin
      if (r_mplier[i]) w_addend = w_addend + (r_mcand << i);
    end
  end

  assign done   = r_busy && (r_cnt == c_last);
  assign result = r_acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start && !r_busy) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= r_acc + w_addend;
      r_mcand  <= r_mcand << MUL_BPC;
      r_mplier <= r_mplier >> MUL_BPC;
      r_cnt    <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/execute_mc.sv
`default_nettype none
// ============================================================================
//  Module      : execute_mc
//  Description : Execute stage: ALU, NZCV flag register, ARM condition
//                evaluation and a multi-cycle multiplier with stall handshake.
//  Ports       : clk, rst (sync, active-low)
//                ValidE, CondE, FlagWE, RegWriteE, MemWriteE, BranchE,
//                NoWriteE, ALUSrcE, ALUControlE, RD1E, RD2E, immExtE - inputs
//                ALUResultE - result; PCSrcE/RegWE/MemWE - gated enables
//                StallE - EX busy; FlagsE - current {N,Z,C,V}
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_mc
  import exec_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidE,
  input  logic [3:0]       CondE,
  input  logic             FlagWE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  input  logic             NoWriteE,
  input  logic             ALUSrcE,
  input  logic [3:0]       ALUControlE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] immExtE,
  output logic [WIDTH-1:0] ALUResultE,
  output logic             PCSrcE,
  output logic             RegWE,
  output logic             MemWE,
  output logic             StallE,
  output logic [3:0]       FlagsE
);

  localparam int c_shw = $clog2(WIDTH);
  localparam int c_msb = WIDTH - 1;

  mc_state_t        r_state;
  flags_t           r_flags;
  logic             r_mul_we;
  logic             r_mul_fwe;

  logic [WIDTH-1:0] w_srcb;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  flags_t           w_new_flags;
  alu_op_t          w_op;
  logic             w_pass;
  logic             w_is_mul;
  logic             w_reserved;
  logic             w_exec;
  logic             w_mul_go;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;

  assign w_op       = alu_op_t'(ALUControlE);
  assign w_srcb     = ALUSrcE ? immExtE : RD2E;
  assign w_add      = {1'b0, RD1E} + {1'b0, w_srcb};
  // Two's-complement subtract: the carry-out is NOT borrow.
  assign w_sub      = {1'b0, RD1E} + {1'b0, ~w_srcb} + {{WIDTH{1'b0}}, 1'b1};
  assign w_pass     = ValidE & cond_eval(cond_t'(CondE), r_flags);
  assign w_is_mul   = (ALUControlE == 4'd8);
  assign w_reserved = (ALUControlE > 4'd8);
  // Single-cycle instruction that actually executes this cycle.
  assign w_exec     = (r_state == IDLE) & w_pass & ~w_is_mul & ~w_reserved;
  assign w_mul_go   = (r_state == IDLE) & w_pass & w_is_mul;

  always_comb begin
    w_res = '0;
    w_c   = r_flags.c;
    w_v   = r_flags.v;
    case (w_op)
      OP_ADD: begin
        w_res = w_add[c_msb:0];
        w_c   = w_add[WIDTH];
        w_v   = (RD1E[c_msb] == w_srcb[c_msb]) && (w_res[c_msb] != RD1E[c_msb]);
      end
      OP_SUB: begin
        w_res = w_sub[c_msb:0];
        w_c   = w_sub[WIDTH];
        w_v   = (RD1E[c_msb] != w_srcb[c_msb]) && (w_res[c_msb] != RD1E[c_msb]);
      end
      OP_AND:  w_res = RD1E & w_srcb;
      OP_ORR:  w_res = RD1E | w_srcb;
      OP_EOR:  w_res = RD1E ^ w_srcb;
      OP_LSL:  w_res = RD1E << w_srcb[c_shw-1:0];
      OP_LSR:  w_res = RD1E >> w_srcb[c_shw-1:0];
      OP_MOV:  w_res = w_srcb;
      default: w_res = '0;
    endcase
    w_new_flags.n = w_res[c_msb];
    w_new_flags.z = (w_res == '0);
    w_new_flags.c = w_c;
    w_new_flags.v = w_v;
  end

  mul_iter #(
    .WIDTH   (WIDTH),
    .MUL_BPC (MUL_BPC)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (w_mul_go),
    .a      (RD1E),
    .b      (w_srcb),
    .done   (w_mul_done),
    .result (w_mul_res)
  );

  // Handshake outputs must react in the issuing cycle, so they are decoded
  // from the registered state rather than registered themselves. All of
  // them are held low while rst is asserted.
  always_comb begin
    ALUResultE = (r_state == DONE) ? w_mul_res : w_res;
    StallE     = rst & (w_mul_go | (r_state == RUN));
    PCSrcE     = rst & w_exec & BranchE;
    MemWE      = rst & w_exec & MemWriteE;
    RegWE      = rst & ((w_exec & RegWriteE & ~NoWriteE) |
                        ((r_state == DONE) & r_mul_we));
    FlagsE     = r_flags;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_flags   <= '0;
      r_mul_we  <= 1'b0;
      r_mul_fwe <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_exec && FlagWE) r_flags <= w_new_flags;
          if (w_mul_go) begin
            r_mul_we  <= RegWriteE & ~NoWriteE;
            r_mul_fwe <= FlagWE;
            r_state   <= RUN;
          end
        end
        RUN: begin
          if (w_mul_done) r_state <= DONE;
        end
        DONE: begin
          // MUL only touches N and Z; C and V carry through.
          if (r_mul_fwe) begin
            r_flags.n <= w_mul_res[c_msb];
            r_flags.z <= (w_mul_res == '0);
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_mc
//  Description : Directed self-checking bench for execute_mc. A second
//                instance with MUL_BPC=1 shares all inputs except ValidE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ValidE, ValidE1, FlagWE, RegWriteE, MemWriteE;
  logic        BranchE, NoWriteE, ALUSrcE;
  logic [3:0]  CondE, ALUControlE;
  logic [31:0] RD1E, RD2E, immExtE;

  logic [31:0] ALUResultE, ALUResultE1;
  logic        PCSrcE, RegWE, MemWE, StallE;
  logic        PCSrcE1, RegWE1, MemWE1, StallE1;
  logic [3:0]  FlagsE, FlagsE1;

  execute_mc #(.WIDTH(32), .MUL_BPC(2)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .CondE(CondE), .FlagWE(FlagWE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .NoWriteE(NoWriteE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .immExtE(immExtE), .ALUResultE(ALUResultE),
    .PCSrcE(PCSrcE), .RegWE(RegWE), .MemWE(MemWE), .StallE(StallE),
    .FlagsE(FlagsE)
  );

  execute_mc #(.WIDTH(32), .MUL_BPC(1)) dut_b1 (
    .clk(clk), .rst(rst), .ValidE(ValidE1), .CondE(CondE), .FlagWE(FlagWE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .NoWriteE(NoWriteE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .immExtE(immExtE), .ALUResultE(ALUResultE1),
    .PCSrcE(PCSrcE1), .RegWE(RegWE1), .MemWE(MemWE1), .StallE(StallE1),
    .FlagsE(FlagsE1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Advance one clock; inputs are driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ValidE = 0; ValidE1 = 0; CondE = 4'd14; FlagWE = 0; RegWriteE = 0;
    MemWriteE = 0; BranchE = 0; NoWriteE = 0; ALUSrcE = 0; ALUControlE = 4'd0;
    RD1E = '0; RD2E = '0; immExtE = '0;
  endtask

  // Drive one instruction on the shared inputs, then let outputs settle.
  task automatic issue(input logic [3:0] op, input logic [3:0] cond,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic src_imm, input logic fwe, input logic rw,
                       input logic mw, input logic br, input logic nw);
    ValidE = 1; CondE = cond; ALUControlE = op; RD1E = a;
    RD2E = src_imm ? 32'h0 : b; immExtE = src_imm ? b : 32'h0;
    ALUSrcE = src_imm; FlagWE = fwe; RegWriteE = rw; MemWriteE = mw;
    BranchE = br; NoWriteE = nw;
    #1;
  endtask

  // Counts consecutive stalled cycles starting now; leaves time inside the
  // first non-stalled cycle. Budget expiry shows up as a wrong count.
  task automatic count_stall(input bit which, output int cnt, output bit en_seen);
    cnt = 0;
    en_seen = 0;
    while (((which ? StallE1 : StallE) === 1'b1) && cnt < 200) begin
      cnt++;
      if (which ? (RegWE1 | MemWE1 | PCSrcE1) : (RegWE | MemWE | PCSrcE)) en_seen = 1;
      @(posedge clk);
      #2;
    end
  endtask

  int cnt;
  bit en_seen;

  initial begin
    clear_in();
    rst = 0;
    RD1E = 32'd5; RD2E = 32'd3;
    tick(); tick(); #1;
    // Reset state
    chk("rst_stall",  {31'b0, StallE}, 32'd0);
    chk("rst_regwe",  {31'b0, RegWE},  32'd0);
    chk("rst_memwe",  {31'b0, MemWE},  32'd0);
    chk("rst_pcsrc",  {31'b0, PCSrcE}, 32'd0);
    chk("rst_flags",  {28'b0, FlagsE}, 32'd0);
    chk("rst_result", ALUResultE,      32'd8);
    rst = 1;
    clear_in();
    tick();

    // ADD overflow
    issue(4'd0, 4'd14, 32'h7FFF_FFFF, 32'd1, 1, 1, 1, 0, 0, 0);
    chk("add_result", ALUResultE, 32'h8000_0000);
    chk("add_regwe", {31'b0, RegWE}, 32'd1);
    tick();
    chk("add_flags", {28'b0, FlagsE}, 32'h9);

    // SUB 5-5 -> Z=1 C=1
    issue(4'd1, 4'd14, 32'd5, 32'd5, 0, 1, 1, 0, 0, 0);
    chk("sub_result", ALUResultE, 32'd0);
    tick();
    chk("sub_flags", {28'b0, FlagsE}, 32'h6);

    // BEQ taken
    issue(4'd0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0, 1, 0);
    chk("beq_pcsrc", {31'b0, PCSrcE}, 32'd1);
    tick();

    // BNE not taken, with write enables requested
    issue(4'd0, 4'd1, 32'd0, 32'd0, 0, 0, 1, 1, 1, 0);
    chk("bne_pcsrc", {31'b0, PCSrcE}, 32'd0);
    chk("bne_memwe", {31'b0, MemWE},  32'd0);
    chk("bne_regwe", {31'b0, RegWE},  32'd0);
    tick();

    // Store with AL
    issue(4'd0, 4'd14, 32'h100, 32'h4, 1, 0, 0, 1, 0, 0);
    chk("str_memwe", {31'b0, MemWE}, 32'd1);
    chk("str_addr",  ALUResultE,     32'h104);
    tick();

    // LSL with flags: N,Z update, C,V preserved (C=1 from SUB)
    issue(4'd5, 4'd14, 32'd1, 32'd31, 1, 1, 1, 0, 0, 0);
    chk("lsl_result", ALUResultE, 32'h8000_0000);
    tick();
    chk("lsl_flags", {28'b0, FlagsE}, 32'hA);

    issue(4'd4, 4'd14, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 1, 0, 0, 0);
    chk("eor_result", ALUResultE, 32'h0000_0FF0);
    tick();
    issue(4'd6, 4'd14, 32'h8000_0000, 32'd31, 1, 0, 1, 0, 0, 0);
    chk("lsr_result", ALUResultE, 32'd1);
    tick();
    issue(4'd7, 4'd14, 32'hDEAD_0000, 32'h1234, 1, 0, 1, 0, 0, 0);
    chk("mov_result", ALUResultE, 32'h1234);
    tick();

    // MUL, MUL_BPC=2: 17 stall cycles
    issue(4'd8, 4'd14, 32'h0001_0003, 32'd7, 0, 1, 1, 0, 0, 0);
    count_stall(0, cnt, en_seen);
    chk("mul_stall_cycles", cnt, 32'd17);
    chk("mul_stall_enables", {31'b0, en_seen}, 32'd0);
    chk("mul_done_result", ALUResultE, 32'h0007_0015);
    chk("mul_done_regwe", {31'b0, RegWE}, 32'd1);
    tick();
    ValidE = 0; #1;
    chk("mul_regwe_once", {31'b0, RegWE}, 32'd0);
    chk("mul_flags", {28'b0, FlagsE}, 32'h2);

    // MUL all-ones
    issue(4'd8, 4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0);
    count_stall(0, cnt, en_seen);
    chk("mulff_result", ALUResultE, 32'd1);
    tick();
    ValidE = 0; #1;
    chk("mulff_flags", {28'b0, FlagsE}, 32'h2);

    // MUL with EQ failing (Z=0)
    issue(4'd8, 4'd0, 32'd3, 32'd3, 0, 1, 1, 0, 0, 0);
    chk("muleq_stall", {31'b0, StallE}, 32'd0);
    chk("muleq_regwe", {31'b0, RegWE},  32'd0);
    tick();
    chk("muleq_stall_next", {31'b0, StallE}, 32'd0);
    ValidE = 0;
    tick();

    // Reset at RUN step 5
    issue(4'd8, 4'd14, 32'd9, 32'd9, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("midrun_stall_before", {31'b0, StallE}, 32'd1);
    rst = 0;
    tick();
    chk("midrun_flags", {28'b0, FlagsE}, 32'd0);
    ValidE = 0; rst = 1; #1;
    chk("midrun_stall_after", {31'b0, StallE}, 32'd0);
    en_seen = 0;
    for (int i = 0; i < 24; i++) begin
      if (RegWE !== 1'b0 || StallE !== 1'b0) en_seen = 1;
      tick();
    end
    chk("midrun_no_pulse", {31'b0, en_seen}, 32'd0);

    // ADD after reset: 0xFFFFFFFF + 1 -> Z=1 C=1
    issue(4'd0, 4'd14, 32'hFFFF_FFFF, 32'd1, 1, 1, 1, 0, 0, 0);
    chk("add2_result", ALUResultE, 32'd0);
    chk("add2_regwe", {31'b0, RegWE}, 32'd1);
    tick();
    chk("add2_flags", {28'b0, FlagsE}, 32'h6);

    // CMP 3-5: no register write, N=1 C=0
    issue(4'd1, 4'd14, 32'd3, 32'd5, 0, 1, 1, 0, 0, 1);
    chk("cmp_regwe", {31'b0, RegWE}, 32'd0);
    chk("cmp_result", ALUResultE, 32'hFFFF_FFFE);
    tick();
    chk("cmp_flags", {28'b0, FlagsE}, 32'h8);

    // BLT taken (N != V)
    issue(4'd0, 4'd11, 32'd0, 32'd0, 0, 0, 0, 0, 1, 0);
    chk("blt_pcsrc", {31'b0, PCSrcE}, 32'd1);
    tick();

    // Reserved opcode 12
    issue(4'd12, 4'd14, 32'd3, 32'd5, 0, 1, 1, 1, 1, 0);
    chk("rsv_result", ALUResultE, 32'd0);
    chk("rsv_enables", {29'b0, RegWE, MemWE, PCSrcE}, 32'd0);
    tick();
    chk("rsv_flags", {28'b0, FlagsE}, 32'h8);

    // ValidE=0: no flag change
    issue(4'd0, 4'd14, 32'd0, 32'd0, 0, 1, 1, 0, 0, 0);
    ValidE = 0; #1;
    chk("novalid_regwe", {31'b0, RegWE}, 32'd0);
    tick();
    chk("novalid_flags", {28'b0, FlagsE}, 32'h8);

    // MUL_BPC=1 instance: 33 stall cycles
    issue(4'd8, 4'd14, 32'h0001_0003, 32'd7, 0, 0, 1, 0, 0, 0);
    ValidE = 0; ValidE1 = 1; #1;
    count_stall(1, cnt, en_seen);
    chk("b1_stall_cycles", cnt, 32'd33);
    chk("b1_result", ALUResultE1, 32'h0007_0015);
    chk("b1_regwe", {31'b0, RegWE1}, 32'd1);
    tick();
    ValidE1 = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_mc.md
Name: execute_mc

Overview:
- Parametrised execute stage for the pipelined ARM-style core.
- Includes the ALU, an NZCV flag register, a full 4-bit condition evaluator, and an iterative multi-cycle multiplier.
- Multiplier latency is reported to the hazard unit through a stall handshake.
- Sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
- WIDTH, 32, datapath width in bits (>= 8, even).
- MUL_BPC, 2, multiplier bits retired per cycle. Must be 1, 2 or 4 and must divide WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- ValidE  in  1  instruction in EX is valid.
- CondE  in  4  ARM condition code.
- FlagWE  in  1  update flags when the instruction executes.
- RegWriteE  in  1  instruction writes the register file.
- MemWriteE  in  1  instruction writes memory.
- BranchE  in  1  instruction is a branch.
- NoWriteE  in  1  compare-type op: suppress the register write.
- ALUSrcE  in  1  0 selects RD2E, 1 selects immExtE as SrcB.
- ALUControlE  in  4  operation code (see package).
- RD1E, RD2E, immExtE  in  WIDTH  operands.
- ALUResultE  out  WIDTH  result.
- PCSrcE  out  1  branch taken.
- RegWE  out  1  gated register write enable.
- MemWE  out  1  gated memory write enable.
- StallE  out  1  EX busy; upstream holds all EX inputs stable while high.
- FlagsE  out  4  current {N,Z,C,V} register.

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, ORR=3, EOR=4, LSL=5, LSR=6, MOV=7, MUL=8.
  - LSL/LSR shift amount is SrcB[log2(WIDTH)-1:0].
  - Codes 9-15 are reserved: result 0, all enables 0, flags unchanged.
- Condition codes: EQ..LE per ARM (0-13); AL=14.
  - 15 is treated as AL.
  - Evaluated against the registered flags at issue.
  - pass = ValidE & cond_true.
- Single-cycle ops:
  - Result is combinational in the same cycle.
  - PCSrcE = pass & BranchE.
  - MemWE = pass & MemWriteE.
  - RegWE = pass & RegWriteE & ~NoWriteE.
  - If pass & FlagWE, flags update at the clock edge:
    - ADD: C = carry-out, V = signed overflow.
    - SUB: C = NOT borrow, V = signed overflow.
    - Logic, shift and MOV: N, Z only; C and V preserved.
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- IDLE with MUL & pass at cycle T:
  - StallE = 1 combinationally in T.
  - All enables are 0 in T.
  - Operands, RegWriteE & ~NoWriteE and FlagWE are latched at the edge.
  - Next state is RUN with step counter = 0.
- RUN:
  - StallE = 1; outputs are don't-care except all enables = 0.
  - Each cycle retires MUL_BPC multiplier bits (shift-add, unsigned low-half product).
  - After WIDTH/MUL_BPC cycles the FSM goes to DONE.
  - StallE is therefore high for WIDTH/MUL_BPC + 1 cycles.
- DONE (one cycle):
  - StallE = 0.
  - ALUResultE = low WIDTH bits of the product.
  - RegWE = latched write enable; PCSrcE = MemWE = 0.
  - If latched FlagWE: N and Z update from the product; C and V preserved.
  - Next state IDLE. Upstream advances on this edge.
- MUL with condition fail: no stall, no writes, stays in IDLE.
- Flags used for the condition check are the value before any update in the same cycle.
- rst = 0 at any clock edge, including mid-RUN:
  - State goes to IDLE, counter = 0, flags = 0000, partial product discarded.
  - Next cycle StallE = 0 and all enables = 0.
- Reset outputs: StallE 0, RegWE 0, MemWE 0, PCSrcE 0, FlagsE 0, ALUResultE = combinational value of the current inputs.
- ValidE = 0 in IDLE: no action and no flag change.
- ValidE is ignored while in RUN or DONE (inputs are held).

Decomposition:
- Package exec_pkg:
  - alu_op_t enum (4-bit).
  - cond_t enum.
  - flags_t packed struct {n,z,c,v}.
  - mc_state_t enum {IDLE,RUN,DONE}.
  - Function cond_eval(cond_t, flags_t) returning a bit.
- Sub-module mul_iter #(WIDTH, MUL_BPC):
  - Handshake: start/done, with operand and result ports.
  - Contains the counter and partial-product registers.
  - Reset follows the parent rst.
- The parent holds the ALU, flag register, condition logic and FSM.

Test Plan (WIDTH=32, MUL_BPC=2 unless noted):
- ADD RD1=0x7FFFFFFF, imm=1, ALUSrc=1, FlagWE=1, AL → result 0x80000000, RegWE=1 same cycle, flags next cycle N=1 Z=0 C=0 V=1.
- SUB 5-5 with FlagWE → Z=1 C=1. Next instruction BEQ (Branch=1, Cond=0) → PCSrcE=1. A following BNE (Cond=1) → PCSrcE=0, MemWE=0, RegWE=0.
- MUL 0x00010003 × 0x00000007, AL, FlagWE=1 → StallE high exactly 17 cycles, DONE cycle result 0x00070015, RegWE=1 for one cycle only, N=0 Z=0, C/V unchanged. Repeat with MUL_BPC=1 → 33 stall cycles.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → result 0x00000001. MUL with Cond=EQ while Z=0 → StallE stays 0, no writes.
- Assert rst=0 at RUN step 5, release next cycle → StallE=0, FlagsE=0000, no RegWE pulse ever. A new ADD then completes normally.
- CMP (SUB with NoWriteE=1, RegWriteE=1, FlagWE=1) → RegWE=0, flags updated. Reserved opcode 12 → result 0, no enables, flags unchanged.
